// File: rtl/stack_unit.sv
// Hardware stack controller in front of the 8-bit data memory: arbitrates the
// memory port between CPU load/store and CU PUSH/POP, and tracks sp and depth.
module stack_unit #(
  parameter logic [7:0]  STACK_TOP   = 8'hFF,
  parameter int unsigned STACK_DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] op,
  input  logic [7:0] push_data,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_w,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_w,
  output logic [7:0] pop_data,
  output logic       pop_valid,
  output logic [7:0] sp,
  output logic [7:0] depth,
  output logic       full,
  output logic       empty,
  output logic       ovf,
  output logic       unf,
  output logic       prot,
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_PUSH  = 2'b01,
    OP_POP   = 2'b10,
    OP_CLEAR = 2'b11
  } stack_op_e;

  localparam logic [7:0] DEPTH_MAX = 8'(STACK_DEPTH);

  stack_op_e  cmd;
  logic       is_push;
  logic       is_pop;
  logic       push_ok;
  logic       pop_ok;
  logic       cpu_in_region;
  logic [7:0] sp_inc;
  logic [7:0] top_offset;
  logic       ovf_set;
  logic       unf_set;
  logic       prot_set;

  assign cmd     = stack_op_e'(op);
  assign is_push = (cmd == OP_PUSH);
  assign is_pop  = (cmd == OP_POP);

  assign full    = (depth == DEPTH_MAX);
  assign empty   = (depth == 8'd0);
  assign push_ok = is_push && !full;
  assign pop_ok  = is_pop && !empty;
  assign sp_inc  = sp + 8'd1;

  // Distance below STACK_TOP; addresses above the top wrap to a large offset,
  // which the legal parameter range guarantees is never below the depth.
  assign top_offset    = STACK_TOP - cpu_addr;
  assign cpu_in_region = (top_offset < DEPTH_MAX);

  assign ovf_set  = is_push && full;
  assign unf_set  = is_pop && empty;
  assign prot_set = cpu_w && !is_push && !is_pop && cpu_in_region;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_w     = cpu_w && !cpu_in_region;
    unique case (cmd)
      OP_PUSH: begin
        if (push_ok) begin
          mem_addr  = sp;
          mem_wdata = push_data;
          mem_w     = 1'b1;
        end else begin
          // A stack command owns the cycle even when rejected: no CPU store.
          mem_w = 1'b0;
        end
      end
      OP_POP: begin
        mem_addr = sp_inc;
        mem_w    = 1'b0;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_w = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp        <= STACK_TOP;
      depth     <= 8'd0;
      pop_data  <= 8'd0;
      pop_valid <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      prot      <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      unique case (cmd)
        OP_PUSH: begin
          if (push_ok) begin
            sp    <= sp - 8'd1;
            depth <= depth + 8'd1;
          end
        end
        OP_POP: begin
          if (pop_ok) begin
            pop_data  <= mem_rdata;
            pop_valid <= 1'b1;
            sp        <= sp_inc;
            depth     <= depth - 8'd1;
          end
        end
        OP_CLEAR: begin
          sp    <= STACK_TOP;
          depth <= 8'd0;
        end
        default: ;
      endcase
      // A new error in the same cycle as err_clr keeps its flag set.
      ovf  <= ovf_set  | (ovf  & ~err_clr);
      unf  <= unf_set  | (unf  & ~err_clr);
      prot <= prot_set | (prot & ~err_clr);
    end
  end

endmodule
